// File: rtl/manchester_frame_assembler_pkg.sv
// Shared definitions for the Manchester frame assembler: state encoding,
// frame error codes and the bit-serial CRC-8 step.
package manchester_frame_assembler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CRC   = 2'd1;
    localparam logic [1:0] ERR_SHORT = 2'd2;
    localparam logic [1:0] ERR_OVF   = 2'd3;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One MSB-first CRC-8 step; a frame whose last byte is its CRC ends at zero.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/manchester_frame_assembler_byte_fifo.sv
// Small synchronous FIFO of {last, data} entries. A push on a full FIFO is
// ignored unless a pop happens in the same cycle.
module manchester_frame_assembler_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [8:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [8:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/manchester_frame_assembler.sv
// Packs decoded Manchester bits into CRC-8 checked frames and streams the bytes
// out through a FIFO with valid/ready and a last flag; status pulses at frame end.
module manchester_frame_assembler
    import manchester_frame_assembler_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 36,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_BYTES    = 32,
    parameter int LEN_W        = $clog2(MAX_BYTES + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_data,
    input  logic             frame_start,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [1:0]       err_code,
    output logic [LEN_W-1:0] frame_len,
    output state_t           fsm_state
);
    // Output handshake: a byte transfers on every clock edge where
    // out_valid && out_ready; out_data/out_last are stable while out_valid
    // is high and not accepted, and read as zero while out_valid is low.
    localparam int TMR_W = $clog2(IDLE_TIMEOUT);

    state_t             state_q, state_d;
    logic [6:0]         shift_q, shift_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         crc_q, crc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [7:0]         stage_q, stage_d;
    logic               stage_vld_q, stage_vld_d;
    logic               ovf_q, ovf_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               rearm_q, rearm_d;
    logic               done_d, ok_d;
    logic [1:0]         err_d;
    logic [LEN_W-1:0]   len_out_d;
    logic               clear_frame;

    logic               push;
    logic [8:0]         push_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic [8:0]         fifo_head;
    logic               fifo_blocked;

    manchester_frame_assembler_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // A full FIFO only frees a slot this cycle if the consumer pops.
    assign fifo_blocked = fifo_full && !out_ready;
    assign out_valid    = !fifo_empty;
    assign out_data     = fifo_empty ? 8'h00 : fifo_head[7:0];
    assign out_last     = !fifo_empty && fifo_head[8];
    assign fsm_state    = state_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        crc_d       = crc_q;
        len_d       = len_q;
        stage_d     = stage_q;
        stage_vld_d = stage_vld_q;
        ovf_d       = ovf_q;
        timer_d     = timer_q;
        rearm_d     = rearm_q;
        push        = 1'b0;
        push_data   = '0;
        clear_frame = 1'b0;
        done_d      = 1'b0;
        ok_d        = 1'b0;
        err_d       = ERR_NONE;
        len_out_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d     = ST_RECEIVE;
                    clear_frame = 1'b1;
                end
            end
            ST_RECEIVE: begin
                timer_d = timer_q + TMR_W'(1);
                if (frame_start) begin
                    state_d = ST_FLUSH;
                    rearm_d = 1'b1;
                end else if (bit_valid) begin
                    timer_d   = '0;
                    shift_d   = {shift_q[5:0], bit_data};
                    crc_d     = crc8_step(crc_q, bit_data);
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (len_q == LEN_W'(MAX_BYTES)) begin
                            ovf_d = 1'b1;
                        end else begin
                            push        = stage_vld_q;
                            push_data   = {1'b0, stage_q};
                            if (stage_vld_q && fifo_blocked) ovf_d = 1'b1;
                            stage_d     = {shift_q, bit_data};
                            stage_vld_d = 1'b1;
                            len_d       = len_q + LEN_W'(1);
                        end
                    end
                end else if (timer_q == TMR_W'(IDLE_TIMEOUT - 1)) begin
                    state_d = ST_FLUSH;
                    rearm_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                // A start with no complete byte is discarded without status.
                if (len_q != '0) begin
                    push      = 1'b1;
                    push_data = {1'b1, stage_q};
                    done_d    = 1'b1;
                    len_out_d = len_q;
                    if (ovf_q || fifo_blocked)                        err_d = ERR_OVF;
                    else if (bit_cnt_q != 3'd0 || len_q < LEN_W'(2))  err_d = ERR_SHORT;
                    else if (crc_q != 8'h00)                          err_d = ERR_CRC;
                    ok_d = (err_d == ERR_NONE);
                end
                if (rearm_q || frame_start) begin
                    state_d     = ST_RECEIVE;
                    clear_frame = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear_frame) begin
            shift_d     = '0;
            bit_cnt_d   = '0;
            crc_d       = '0;
            len_d       = '0;
            stage_vld_d = 1'b0;
            ovf_d       = 1'b0;
            timer_d     = '0;
            rearm_d     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            crc_q       <= '0;
            len_q       <= '0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            ovf_q       <= 1'b0;
            timer_q     <= '0;
            rearm_q     <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            err_code    <= ERR_NONE;
            frame_len   <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
            ovf_q       <= ovf_d;
            timer_q     <= timer_d;
            rearm_q     <= rearm_d;
            frame_done  <= done_d;
            frame_ok    <= ok_d;
            err_code    <= err_d;
            frame_len   <= len_out_d;
        end
    end

endmodule
